// File: rtl/fractcam_pkg.sv
// Shared constants and helper functions for the fractcam match-line encoder.
// The lowest-set-bit helper is shared by the per-segment encoders and by the segment select.
package fractcam_pkg;

    localparam int DEPTH_DEFAULT     = 64;
    localparam int SEG_WIDTH_DEFAULT = 8;
    localparam int LSB_MAX_WIDTH     = 256;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index of the lowest set bit among the first `width` bits; 0 when none are set.
    function automatic int lowest_set_bit(input logic [LSB_MAX_WIDTH-1:0] vec, input int width);
        int idx;
        idx = 0;
        for (int i = LSB_MAX_WIDTH - 1; i >= 0; i--) begin
            if (i < width && vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fractcam_penc_seg.sv
// Combinational priority encoder over one slice: any-hit, lowest set index, and two-or-more flag.
// Used for the per-segment stage-1 encoders and for the stage-2 segment select.
module fractcam_penc_seg
    import fractcam_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int IDX_WIDTH = (WIDTH > 1) ? clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     vec,
    output logic                 hit,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 multi
);

    logic [LSB_MAX_WIDTH-1:0] vec_wide;

    always_comb begin
        vec_wide            = '0;
        vec_wide[WIDTH-1:0] = vec;
        hit                 = |vec;
        // Clearing the lowest set bit leaves something behind only if two or more were set.
        multi               = |(vec & (vec - WIDTH'(1)));
        idx                 = IDX_WIDTH'(lowest_set_bit(vec_wide, WIDTH));
    end

endmodule

// File: rtl/fractcam_match_encoder.sv
// Two-stage pipelined priority encoder for the fractcam match lines, lowest index wins.
// A single advance enable stalls both stages together under downstream backpressure.
module fractcam_match_encoder
    import fractcam_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int SEG_WIDTH  = SEG_WIDTH_DEFAULT,
    parameter int TAG_WIDTH  = 8,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DEPTH-1:0]      s_match,
    input  logic [TAG_WIDTH-1:0]  s_tag,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_hit,
    output logic                  m_multi,
    output logic [TAG_WIDTH-1:0]  m_tag,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int NSEG      = DEPTH / SEG_WIDTH;
    localparam int SEG_IDX_W = clog2(SEG_WIDTH);
    localparam int SEL_W     = (NSEG > 1) ? clog2(NSEG) : 1;

    if ((DEPTH % SEG_WIDTH) != 0 || SEG_WIDTH < 2 || (SEG_WIDTH & (SEG_WIDTH - 1)) != 0
        || NSEG > LSB_MAX_WIDTH || SEG_WIDTH > LSB_MAX_WIDTH) begin : g_bad_params
        $error("fractcam_match_encoder: DEPTH must be a multiple of SEG_WIDTH, SEG_WIDTH a power of 2 >= 2");
    end

    logic                           en;
    logic [NSEG-1:0]                seg_hit;
    logic [NSEG-1:0]                seg_multi;
    logic [NSEG-1:0][SEG_IDX_W-1:0] seg_idx;

    logic                           v1;
    logic [TAG_WIDTH-1:0]           s1_tag;
    logic [NSEG-1:0]                s1_hit;
    logic [NSEG-1:0]                s1_multi;
    logic [NSEG-1:0][SEG_IDX_W-1:0] s1_idx;

    logic                           sel_hit;
    logic                           sel_multi;
    logic [SEL_W-1:0]               sel_g;
    logic [ADDR_WIDTH-1:0]          addr_next;
    logic                           multi_next;

    assign en      = !m_valid || m_ready;
    assign s_ready = en;

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        fractcam_penc_seg #(
            .WIDTH     (SEG_WIDTH),
            .IDX_WIDTH (SEG_IDX_W)
        ) u_seg (
            .vec   (s_match[g*SEG_WIDTH +: SEG_WIDTH]),
            .hit   (seg_hit[g]),
            .idx   (seg_idx[g]),
            .multi (seg_multi[g])
        );
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        // NOTE: reset clears data as well as valid, so nothing stale is ever visible on the outputs.
        if (rst) begin
            v1       <= 1'b0;
            s1_tag   <= '0;
            s1_hit   <= '0;
            s1_multi <= '0;
            s1_idx   <= '0;
        end else if (en) begin
            v1       <= s_valid && s_ready;
            s1_tag   <= s_tag;
            s1_hit   <= seg_hit;
            s1_multi <= seg_multi;
            s1_idx   <= seg_idx;
        end
    end

    fractcam_penc_seg #(
        .WIDTH     (NSEG),
        .IDX_WIDTH (SEL_W)
    ) u_sel (
        .vec   (s1_hit),
        .hit   (sel_hit),
        .idx   (sel_g),
        .multi (sel_multi)
    );

    always_comb begin
        // NOTE: default first so no path through this block can infer a latch.
        addr_next  = '0;
        multi_next = (|s1_multi) || sel_multi;
        if (sel_hit) begin
            addr_next = (ADDR_WIDTH'(sel_g) << SEG_IDX_W) | ADDR_WIDTH'(s1_idx[sel_g]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_hit   <= 1'b0;
            m_multi <= 1'b0;
            m_addr  <= '0;
            m_tag   <= '0;
        end else if (en) begin
            m_valid <= v1;
            m_hit   <= sel_hit;
            m_multi <= multi_next;
            m_addr  <= addr_next;
            m_tag   <= s1_tag;
        end
    end

endmodule

// File: tb/tb_fractcam_match_encoder.sv
// Randomized scoreboard bench: a 64/8 and a 32/4 instance run in lockstep on the same beats.
// Expected beats come from a plain lowest-bit / bit-count model of the match vector.
module tb_fractcam_match_encoder;

    typedef struct {
        int addr;
        bit hit;
        bit multi;
        int tag;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_match;
    logic [7:0]  s_tag;
    logic        s_valid;
    logic        m_ready;

    logic        s_ready_a, m_hit_a, m_multi_a, m_valid_a;
    logic [5:0]  m_addr_a;
    logic [7:0]  m_tag_a;
    logic        s_ready_b, m_hit_b, m_multi_b, m_valid_b;
    logic [4:0]  m_addr_b;
    logic [7:0]  m_tag_b;

    int    err_cnt = 0;
    int    chk_cnt = 0;
    int    out_a   = 0;
    int    out_b   = 0;
    beat_t qa[$];
    beat_t qb[$];

    always #5 clk = ~clk;

    fractcam_match_encoder #(.DEPTH(64), .SEG_WIDTH(8), .TAG_WIDTH(8)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .s_match (s_match),
        .s_tag   (s_tag),
        .s_valid (s_valid),
        .s_ready (s_ready_a),
        .m_addr  (m_addr_a),
        .m_hit   (m_hit_a),
        .m_multi (m_multi_a),
        .m_tag   (m_tag_a),
        .m_valid (m_valid_a),
        .m_ready (m_ready)
    );

    fractcam_match_encoder #(.DEPTH(32), .SEG_WIDTH(4), .TAG_WIDTH(8)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .s_match (s_match[31:0]),
        .s_tag   (s_tag),
        .s_valid (s_valid),
        .s_ready (s_ready_b),
        .m_addr  (m_addr_b),
        .m_hit   (m_hit_b),
        .m_multi (m_multi_b),
        .m_tag   (m_tag_b),
        .m_valid (m_valid_b),
        .m_ready (m_ready)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic beat_t model(input logic [63:0] vec, input int width, input logic [7:0] tag);
        beat_t b;
        int    n;
        n       = 0;
        b.addr  = 0;
        b.tag   = int'(tag);
        for (int i = width - 1; i >= 0; i--) begin
            if (vec[i]) begin
                b.addr = i;
                n++;
            end
        end
        b.hit   = (n > 0);
        b.multi = (n > 1);
        return b;
    endfunction

    function automatic logic [63:0] rand_vec();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 4))
            0: v = '0;
            1: v = 64'd1 << $urandom_range(0, 63);
            2: v = v & {$urandom, $urandom} & {$urandom, $urandom};
            3: v = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
            default: ;
        endcase
        return v;
    endfunction

    // Scoreboard: sampled mid-cycle, so these are the values the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (m_valid_a) begin
                if (qa.size() == 0) check("a_unexpected_beat", 64'd1, 64'd0);
                else begin
                    check("a_addr",  64'(m_addr_a),  64'(qa[0].addr));
                    check("a_hit",   64'(m_hit_a),   64'(qa[0].hit));
                    check("a_multi", 64'(m_multi_a), 64'(qa[0].multi));
                    check("a_tag",   64'(m_tag_a),   64'(qa[0].tag));
                    if (m_ready) begin
                        void'(qa.pop_front());
                        out_a++;
                    end
                end
            end
            if (m_valid_b) begin
                if (qb.size() == 0) check("b_unexpected_beat", 64'd1, 64'd0);
                else begin
                    check("b_addr",  64'(m_addr_b),  64'(qb[0].addr));
                    check("b_hit",   64'(m_hit_b),   64'(qb[0].hit));
                    check("b_multi", 64'(m_multi_b), 64'(qb[0].multi));
                    check("b_tag",   64'(m_tag_b),   64'(qb[0].tag));
                    if (m_ready) begin
                        void'(qb.pop_front());
                        out_b++;
                    end
                end
            end
            if (s_valid && s_ready_a) qa.push_back(model(s_match, 64, s_tag));
            if (s_valid && s_ready_b) qb.push_back(model(s_match, 32, s_tag));
        end
    end

    task automatic send(input logic [63:0] vec, input logic [7:0] tag);
        bit acc;
        int budget;
        s_match = vec;
        s_tag   = tag;
        s_valid = 1'b1;
        acc     = 1'b0;
        budget  = 0;
        while (!acc && budget < 100) begin
            @(negedge clk);
            acc = s_ready_a;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((qa.size() != 0 || qb.size() != 0) && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_left", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic directed(input string name, input logic [63:0] vec, input logic [7:0] tag,
                            input int ea, input bit eh, input bit em);
        send(vec, tag);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 64'(m_valid_a), 64'd1);
        check({name, "_addr"},  64'(m_addr_a),  64'(ea));
        check({name, "_hit"},   64'(m_hit_a),   64'(eh));
        check({name, "_multi"}, 64'(m_multi_a), 64'(em));
        check({name, "_tag"},   64'(m_tag_a),   64'(tag));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base_a;
        int base_b;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_match = '0;
        s_tag   = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_m_valid_a", 64'(m_valid_a), 64'd0);
        check("rst_m_valid_b", 64'(m_valid_b), 64'd0);
        check("rst_m_addr",    64'(m_addr_a),  64'd0);
        check("rst_s_ready",   64'(s_ready_a), 64'd1);

        // Exact two-cycle latency for a single beat.
        s_match = 64'd1 << 37;
        s_tag   = 8'h5A;
        s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
        check("lat1_m_valid", 64'(m_valid_a), 64'd0);
        @(posedge clk);
        #1;
        check("lat2_m_valid", 64'(m_valid_a), 64'd1);
        check("lat2_addr",    64'(m_addr_a),  64'd37);
        check("lat2_hit",     64'(m_hit_a),   64'd1);
        check("lat2_multi",   64'(m_multi_a), 64'd0);
        check("lat2_tag",     64'(m_tag_a),   64'h5A);
        @(posedge clk);
        #1;
        check("lat3_m_valid", 64'(m_valid_a), 64'd0);

        directed("two_segs",  (64'd1 << 9) | (64'd1 << 50), 8'h11, 9, 1'b1, 1'b1);
        directed("same_seg",  (64'd1 << 3) | (64'd1 << 5),  8'h22, 3, 1'b1, 1'b1);
        directed("no_match",  64'd0,                        8'h33, 0, 1'b0, 1'b0);
        directed("all_ones",  '1,                           8'h44, 0, 1'b1, 1'b1);
        directed("top_entry", 64'd1 << 63,                  8'h55, 63, 1'b1, 1'b0);

        // Back-to-back stream at full rate.
        base_a = out_a;
        base_b = out_b;
        for (int i = 0; i < 16; i++) send(rand_vec(), 8'(i + 8'h80));
        drain();
        check("stream_count_a", 64'(out_a - base_a), 64'd16);
        check("stream_count_b", 64'(out_b - base_b), 64'd16);

        // Five-cycle backpressure in the middle of a stream.
        base_a = out_a;
        fork
            begin
                for (int i = 0; i < 20; i++) send(rand_vec(), 8'(i + 8'hC0));
            end
            begin
                repeat (6) @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_s_ready_a", 64'(s_ready_a), 64'd0);
                    check("stall_s_ready_b", 64'(s_ready_b), 64'd0);
                    check("stall_m_valid",   64'(m_valid_a), 64'd1);
                end
                @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        drain();
        check("stall_count_a", 64'(out_a - base_a), 64'd20);

        // Reset with two beats in flight discards both.
        send(64'd1 << 40, 8'h66);
        send(64'd1 << 7,  8'h77);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_m_valid_a", 64'(m_valid_a), 64'd0);
        check("midrst_m_valid_b", 64'(m_valid_b), 64'd0);
        check("midrst_m_addr",    64'(m_addr_a),  64'd0);
        check("midrst_m_hit",     64'(m_hit_a),   64'd0);
        check("midrst_m_tag",     64'(m_tag_a),   64'd0);
        check("midrst_s_ready",   64'(s_ready_a), 64'd1);
        @(posedge clk);
        #1;
        check("midrst_flushed",   64'(m_valid_a), 64'd0);
        directed("post_rst", 64'd1 << 12, 8'h99, 12, 1'b1, 1'b0);

        // Random backpressure against a random stream.
        base_a = out_a;
        base_b = out_b;
        fork
            begin
                for (int i = 0; i < 30; i++) send(rand_vec(), 8'($urandom));
            end
            begin
                repeat (50) begin
                    @(posedge clk);
                    #1 m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        drain();
        check("rand_bp_count_a", 64'(out_a - base_a), 64'd30);
        check("rand_bp_count_b", 64'(out_b - base_b), 64'd30);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
